// File: rtl/aes_input_sharing_unit_pkg.sv
// Shared types and sizing helpers for the AES input sharing unit.
// Word-count and counter-width math lives here so the interface and the core agree on it.
package aes_input_sharing_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  localparam int BLOCK_W = 128;
  localparam int PAIR_W  = 256;

  // Random words needed to mask the key/plaintext pair of every non-zero share.
  function automatic int calc_nw(input int d, input int rnd_w);
    return (d > 1) ? (PAIR_W * (d - 1)) / rnd_w : 0;
  endfunction

  function automatic int calc_cnt_w(input int nw);
    return (nw < 1) ? 1 : $clog2(nw + 1);
  endfunction

endpackage

// File: rtl/aes_input_sharing_unit_if.sv
// Handshake and data bundle between the unmasked source, the random stream and the masked core.
interface aes_input_sharing_unit_if #(
  parameter int d     = 2,
  parameter int RND_W = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [127:0]         in_plaintext;
  logic [127:0]         in_key;
  logic                 in_rnd_valid;
  logic                 in_rnd_ready;
  logic [RND_W-1:0]     in_rnd;
  logic [128*d-1:0]     out_shares_plaintext;
  logic [128*d-1:0]     out_shares_key;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_valid, in_plaintext, in_key, in_rnd_valid, in_rnd, out_ready,
    input  in_ready, in_rnd_ready, out_shares_plaintext, out_shares_key, out_valid
  );

  modport slave (
    input  in_valid, in_plaintext, in_key, in_rnd_valid, in_rnd, out_ready,
    output in_ready, in_rnd_ready, out_shares_plaintext, out_shares_key, out_valid
  );
endinterface

// File: rtl/aes_input_sharing_unit.sv
// Splits an unmasked plaintext/key into d Boolean shares using a word-wide random stream.
// Share 0 is masked in place as each random word arrives; shares 1..d-1 are the random words.
module aes_input_sharing_unit
  import aes_input_sharing_unit_pkg::*;
#(
  parameter int d     = 2,
  parameter int RND_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  aes_input_sharing_unit_if.slave   bus
);

  localparam int NW = calc_nw(d, RND_W);
  localparam int CW = calc_cnt_w(NW);
  localparam int MW = (d > 1) ? PAIR_W * (d - 1) : 1;

  if ((PAIR_W % RND_W) != 0 || d < 1) begin : g_bad_params
    $error("aes_input_sharing_unit: RND_W must divide 256 and d must be >= 1");
  end

  state_e             state;
  logic [CW-1:0]      cnt;
  logic [PAIR_W-1:0]  data_q;
  logic               in_ready_q;
  logic               in_rnd_ready_q;
  logic               out_valid_q;
  logic               in_fire;
  logic               rnd_fire;
  int                 word_base;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign rnd_fire = bus.in_rnd_valid & in_rnd_ready_q;

  always_comb begin
    word_base = (RND_W * int'(cnt)) % PAIR_W;
  end

  // Handshake flags are registered alongside the state so each is a clean state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      in_ready_q     <= 1'b1;
      in_rnd_ready_q <= 1'b0;
      out_valid_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_fire) begin
            cnt        <= '0;
            in_ready_q <= 1'b0;
            if (NW > 0) begin
              state          <= ST_FILL;
              in_rnd_ready_q <= 1'b1;
            end else begin
              state       <= ST_OUT;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (rnd_fire) begin
            if (int'(cnt) == NW - 1) begin
              state          <= ST_OUT;
              in_rnd_ready_q <= 1'b0;
              out_valid_q    <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state          <= ST_IDLE;
          cnt            <= '0;
          in_ready_q     <= 1'b1;
          in_rnd_ready_q <= 1'b0;
          out_valid_q    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (in_fire) begin
      data_q <= {bus.in_key, bus.in_plaintext};
    end else if (rnd_fire) begin
      data_q[word_base +: RND_W] <= data_q[word_base +: RND_W] ^ bus.in_rnd;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.in_rnd_ready = in_rnd_ready_q;
  assign bus.out_valid    = out_valid_q;

  // Gating keeps partially masked share 0 off the port while FILL is in progress.
  assign bus.out_shares_plaintext[BLOCK_W-1:0] = data_q[BLOCK_W-1:0] & {BLOCK_W{out_valid_q}};
  assign bus.out_shares_key[BLOCK_W-1:0]       = data_q[PAIR_W-1:BLOCK_W] & {BLOCK_W{out_valid_q}};

  if (d > 1) begin : g_mask
    logic [MW-1:0] mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mask_q <= '0;
      end else if (in_fire) begin
        mask_q <= '0;
      end else if (rnd_fire) begin
        mask_q[RND_W * int'(cnt) +: RND_W] <= bus.in_rnd;
      end
    end

    for (genvar j = 1; j < d; j++) begin : g_share
      assign bus.out_shares_plaintext[BLOCK_W*j +: BLOCK_W] =
        mask_q[PAIR_W*(j-1) +: BLOCK_W] & {BLOCK_W{out_valid_q}};
      assign bus.out_shares_key[BLOCK_W*j +: BLOCK_W] =
        mask_q[PAIR_W*(j-1) + BLOCK_W +: BLOCK_W] & {BLOCK_W{out_valid_q}};
    end
  end

endmodule

// File: tb/tb_aes_input_sharing_unit.sv
// Directed bench for the input sharing unit: d=2 instance for most scenarios, d=1 instance for pass-through.
module tb_aes_input_sharing_unit;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  aes_input_sharing_unit_if #(.d(2), .RND_W(32)) bus2 ();
  aes_input_sharing_unit_if #(.d(1), .RND_W(32)) bus1 ();

  aes_input_sharing_unit #(.d(2), .RND_W(32)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  aes_input_sharing_unit #(.d(1), .RND_W(32)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  // Starts an operation on the d=2 unit with a constant random word and counts
  // edges from the accepting edge until out_valid is seen.
  task automatic drive_const_op(input logic [127:0] pt, input logic [127:0] key,
                                input logic [31:0] word, output int lat);
    bus2.in_plaintext = pt;
    bus2.in_key       = key;
    bus2.in_valid     = 1'b1;
    bus2.in_rnd_valid = 1'b1;
    bus2.in_rnd       = word;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      bus2.in_valid = 1'b0;
      if (bus2.out_valid === 1'b1) break;
    end
  endtask

  task automatic release_out2();
    bus2.out_ready = 1'b1;
    @(posedge clk); #1;
    bus2.out_ready    = 1'b0;
    bus2.in_rnd_valid = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (bus2.in_ready !== 1'b1 || bus2.in_rnd_ready !== 1'b0 || bus2.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags got rdy=%b rnd_rdy=%b vld=%b want 1 0 0",
               bus2.in_ready, bus2.in_rnd_ready, bus2.out_valid);
    end
    total++;
    if (bus2.out_shares_plaintext !== 256'h0 || bus2.out_shares_key !== 256'h0) begin
      bad++;
      $display("FAIL reset_shares got pt=%h key=%h want 0", bus2.out_shares_plaintext, bus2.out_shares_key);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus2.in_ready !== 1'b1 || bus2.out_valid !== 1'b0 || bus1.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL post_reset got rdy2=%b vld2=%b rdy1=%b want 1 0 1",
               bus2.in_ready, bus2.out_valid, bus1.in_ready);
    end
  endtask

  task automatic test_zero_rnd();
    int lat;
    drive_const_op(PT, KEY, 32'h0, lat);
    total++;
    if (lat !== 9) begin bad++; $display("FAIL zero_latency got=%0d want=9", lat); end
    total++;
    if (bus2.out_shares_plaintext[127:0] !== PT || bus2.out_shares_key[127:0] !== KEY) begin
      bad++;
      $display("FAIL zero_share0 got pt=%h key=%h want pt=%h key=%h",
               bus2.out_shares_plaintext[127:0], bus2.out_shares_key[127:0], PT, KEY);
    end
    total++;
    if (bus2.out_shares_plaintext[255:128] !== 128'h0 || bus2.out_shares_key[255:128] !== 128'h0) begin
      bad++;
      $display("FAIL zero_share1 got pt=%h key=%h want 0",
               bus2.out_shares_plaintext[255:128], bus2.out_shares_key[255:128]);
    end
    // Hold with out_ready low while random words keep arriving; nothing may move.
    bus2.in_rnd = 32'hffffffff;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus2.out_valid !== 1'b1 || bus2.out_shares_plaintext !== {128'h0, PT}
        || bus2.out_shares_key !== {128'h0, KEY}) begin
      bad++;
      $display("FAIL zero_hold got vld=%b pt=%h want vld=1 pt=%h",
               bus2.out_valid, bus2.out_shares_plaintext, {128'h0, PT});
    end
    release_out2();
    total++;
    if (bus2.out_valid !== 1'b0 || bus2.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL zero_release got vld=%b rdy=%b want 0 1", bus2.out_valid, bus2.in_ready);
    end
  endtask

  task automatic test_ones_rnd();
    int lat;
    drive_const_op(PT, KEY, 32'hffffffff, lat);
    total++;
    if (lat !== 9) begin bad++; $display("FAIL ones_latency got=%0d want=9", lat); end
    total++;
    if (bus2.out_shares_plaintext[127:0] !== 128'hffeeddccbbaa99887766554433221100
        || bus2.out_shares_key[127:0] !== 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0) begin
      bad++;
      $display("FAIL ones_share0 got pt=%h key=%h want inverted",
               bus2.out_shares_plaintext[127:0], bus2.out_shares_key[127:0]);
    end
    total++;
    if (bus2.out_shares_plaintext[255:128] !== {128{1'b1}} || bus2.out_shares_key[255:128] !== {128{1'b1}}) begin
      bad++;
      $display("FAIL ones_share1 got pt=%h key=%h want all ones",
               bus2.out_shares_plaintext[255:128], bus2.out_shares_key[255:128]);
    end
    total++;
    if ((bus2.out_shares_plaintext[127:0] ^ bus2.out_shares_plaintext[255:128]) !== PT
        || (bus2.out_shares_key[127:0] ^ bus2.out_shares_key[255:128]) !== KEY) begin
      bad++;
      $display("FAIL ones_recombine got pt=%h want=%h",
               bus2.out_shares_plaintext[127:0] ^ bus2.out_shares_plaintext[255:128], PT);
    end
    release_out2();
  endtask

  task automatic test_random_gaps();
    logic [127:0] pt, key;
    logic [31:0]  w [8];
    int           gap, hold;
    for (int v = 0; v < 150; v++) begin
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < 8; k++) w[k] = $urandom;
      total++;
      if (bus2.in_ready !== 1'b1) begin
        bad++; $display("FAIL rand_idle_ready vec=%0d got=%b want=1", v, bus2.in_ready);
      end
      bus2.in_plaintext = pt;
      bus2.in_key       = key;
      bus2.in_valid     = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 8; k++) begin
        gap = $urandom_range(0, 6);
        bus2.in_rnd_valid = 1'b0;
        // A stray input request mid-fill must be ignored.
        bus2.in_valid     = (k == 2);
        bus2.in_plaintext = ~pt;
        repeat (gap) begin @(posedge clk); #1; end
        bus2.in_valid     = 1'b0;
        bus2.in_rnd_valid = 1'b1;
        bus2.in_rnd       = w[k];
        total++;
        if (bus2.in_rnd_ready !== 1'b1) begin
          bad++; $display("FAIL rand_rnd_ready vec=%0d word=%0d got=%b want=1", v, k, bus2.in_rnd_ready);
        end
        @(posedge clk); #1;
        total++;
        if (bus2.out_valid !== (k == 7)) begin
          bad++; $display("FAIL rand_valid_timing vec=%0d word=%0d got=%b want=%b", v, k, bus2.out_valid, k == 7);
        end
      end
      bus2.in_rnd_valid = 1'b0;
      hold = $urandom_range(0, 3);
      repeat (hold) begin @(posedge clk); #1; end
      total++;
      if (bus2.out_valid !== 1'b1 || bus2.out_shares_plaintext[255:128] !== {w[3], w[2], w[1], w[0]}
          || bus2.out_shares_key[255:128] !== {w[7], w[6], w[5], w[4]}) begin
        bad++;
        $display("FAIL rand_share1 vec=%0d got pt=%h key=%h want pt=%h key=%h", v,
                 bus2.out_shares_plaintext[255:128], bus2.out_shares_key[255:128],
                 {w[3], w[2], w[1], w[0]}, {w[7], w[6], w[5], w[4]});
      end
      total++;
      if ((bus2.out_shares_plaintext[127:0] ^ bus2.out_shares_plaintext[255:128]) !== pt
          || (bus2.out_shares_key[127:0] ^ bus2.out_shares_key[255:128]) !== key) begin
        bad++;
        $display("FAIL rand_recombine vec=%0d got pt=%h want=%h", v,
                 bus2.out_shares_plaintext[127:0] ^ bus2.out_shares_plaintext[255:128], pt);
      end
      release_out2();
    end
  endtask

  task automatic test_reset_mid_fill();
    int lat;
    bus2.in_plaintext = PT;
    bus2.in_key       = KEY;
    bus2.in_valid     = 1'b1;
    @(posedge clk); #1;
    bus2.in_valid     = 1'b0;
    bus2.in_rnd_valid = 1'b1;
    bus2.in_rnd       = 32'h12345678;
    repeat (4) @(posedge clk);
    #1;
    bus2.in_rnd_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    total++;
    if (bus2.out_valid !== 1'b0 || bus2.in_ready !== 1'b1 || bus2.in_rnd_ready !== 1'b0) begin
      bad++;
      $display("FAIL midreset_flags got vld=%b rdy=%b rnd_rdy=%b want 0 1 0",
               bus2.out_valid, bus2.in_ready, bus2.in_rnd_ready);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus2.in_ready !== 1'b1 || bus2.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_idle got rdy=%b vld=%b want 1 0", bus2.in_ready, bus2.out_valid);
    end
    drive_const_op(PT, KEY, 32'h5a5a5a5a, lat);
    total++;
    if (lat !== 9) begin bad++; $display("FAIL midreset_latency got=%0d want=9", lat); end
    total++;
    if (bus2.out_shares_plaintext !== {{4{32'h5a5a5a5a}}, PT ^ {4{32'h5a5a5a5a}}}
        || bus2.out_shares_key !== {{4{32'h5a5a5a5a}}, KEY ^ {4{32'h5a5a5a5a}}}) begin
      bad++;
      $display("FAIL midreset_shares got pt=%h key=%h", bus2.out_shares_plaintext, bus2.out_shares_key);
    end
    release_out2();
  endtask

  task automatic test_d1();
    int   lat;
    logic rnd_seen;
    rnd_seen = 1'b0;
    bus1.in_plaintext = PT;
    bus1.in_key       = KEY;
    bus1.in_valid     = 1'b1;
    bus1.in_rnd_valid = 1'b1;
    bus1.in_rnd       = 32'hdeadbeef;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus1.in_rnd_ready !== 1'b0) rnd_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
      bus1.in_valid = 1'b0;
      if (bus1.out_valid === 1'b1) break;
    end
    total++;
    if (lat !== 1) begin bad++; $display("FAIL d1_latency got=%0d want=1", lat); end
    repeat (2) begin
      if (bus1.in_rnd_ready !== 1'b0) rnd_seen = 1'b1;
      @(posedge clk); #1;
    end
    total++;
    if (bus1.out_shares_plaintext !== PT || bus1.out_shares_key !== KEY || bus1.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL d1_share0 got pt=%h key=%h vld=%b want pt=%h key=%h vld=1",
               bus1.out_shares_plaintext, bus1.out_shares_key, bus1.out_valid, PT, KEY);
    end
    bus1.out_ready = 1'b1;
    if (bus1.in_rnd_ready !== 1'b0) rnd_seen = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready    = 1'b0;
    bus1.in_rnd_valid = 1'b0;
    total++;
    if (rnd_seen !== 1'b0) begin bad++; $display("FAIL d1_rnd_ready got=1 want=0"); end
    total++;
    if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL d1_release got vld=%b rdy=%b want 0 1", bus1.out_valid, bus1.in_ready);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_plaintext = '0; bus2.in_key = '0;
    bus2.in_rnd_valid = 1'b0; bus2.in_rnd = '0; bus2.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_plaintext = '0; bus1.in_key = '0;
    bus1.in_rnd_valid = 1'b0; bus1.in_rnd = '0; bus1.out_ready = 1'b0;
    #12;
    test_reset();
    test_zero_rnd();
    test_ones_rnd();
    test_random_gaps();
    test_reset_mid_fill();
    test_d1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
